// File: rtl/rv_pkg.sv
// Shared definitions for the U-type instruction sequencer: opcodes, pcop
// encodings, FSM state type and an opcode legality helper.
package rv_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [1:0] PCOP_SEQ     = 2'd0;
  localparam logic [1:0] PCOP_SEQ_ALT = 2'd1;
  localparam logic [1:0] PCOP_JUMP    = 2'd2;
  localparam logic [1:0] PCOP_FAULT   = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } state_t;

  function automatic logic is_u_type(input logic [6:0] op);
    return (op == OPC_LUI) || (op == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/u_fetch_timer.sv
// Counts non-ready fetch cycles and flags the cycle on which the wait
// budget is exhausted.
module u_fetch_timer #(
  parameter int unsigned FETCH_TMO = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       count_en,
  input  logic       clear,
  output logic [7:0] wait_cnt,
  output logic       timeout
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wait_cnt <= 8'd0;
    end else if (count_en) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Fires on the FETCH_TMO-th consecutive non-ready cycle.
  assign timeout = count_en && (wait_cnt == 8'(FETCH_TMO - 1));

endmodule

// File: rtl/u_pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer that owns the PC and drives an
// external combinational U-type exec unit and the register file write port.
module u_pc_sequencer
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned FETCH_TMO = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [6:0]  ex_op,
  output logic [19:0] ex_imm,
  output logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [1:0]  ex_pcop,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault
);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] wdata_q;
  logic [1:0]  pcop_q;
  logic [7:0]  wait_cnt;
  logic        tmo_hit;
  logic        in_fetch;
  logic        halt_take;
  logic        fetch_active;
  logic [4:0]  rd;

  assign rd       = ir_q[11:7];
  assign in_fetch = (state_q == ST_FETCH);
  // A zero wait count marks the first FETCH cycle, the only point where halt_req is honoured.
  assign halt_take    = in_fetch && (wait_cnt == 8'd0) && halt_req;
  assign fetch_active = in_fetch && !halt_take;

  u_fetch_timer #(
    .FETCH_TMO(FETCH_TMO)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .count_en(fetch_active && !imem_ready),
    .clear   (!in_fetch),
    .wait_cnt(wait_cnt),
    .timeout (tmo_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (halt_take)       state_d = ST_HALT;
        else if (imem_ready) state_d = ST_DECODE;
        else if (tmo_hit)    state_d = ST_FAULT;
      end
      ST_DECODE: state_d = is_u_type(ir_q[6:0]) ? ST_EXEC : ST_FAULT;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = (pcop_q == PCOP_FAULT) ? ST_FAULT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'd0;
    ex_op     = 7'd0;
    ex_imm    = 20'd0;
    ex_pc     = 32'd0;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = 32'd0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req  = fetch_active;
        imem_addr = fetch_active ? pc_q : 32'd0;
      end
      ST_EXEC: begin
        ex_op  = ir_q[6:0];
        ex_imm = ir_q[31:12];
        ex_pc  = pc_q;
      end
      ST_WB: begin
        if ((rd != 5'd0) && (pcop_q != PCOP_FAULT)) begin
          rf_we    = 1'b1;
          rf_waddr = rd;
          rf_wdata = wdata_q;
        end
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      wdata_q <= 32'd0;
      pcop_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (fetch_active && imem_ready) begin
        ir_q <= imem_rdata;
      end
      if (state_q == ST_EXEC) begin
        wdata_q <= ex_result;
        pcop_q  <= ex_pcop;
      end
      // A faulting pcop leaves the PC on the faulting instruction.
      if (state_q == ST_WB) begin
        case (pcop_q)
          PCOP_SEQ, PCOP_SEQ_ALT: pc_q <= pc_q + 32'd4;
          PCOP_JUMP:              pc_q <= wdata_q & ~32'h3;
          PCOP_FAULT:             pc_q <= pc_q;
          default:                pc_q <= pc_q;
        endcase
      end
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_u_pc_sequencer.sv
// Self-checking bench for u_pc_sequencer: plays imem and exec unit, and checks
// each instruction against an instruction-level reference model.
module tb_u_pc_sequencer;

  localparam int unsigned TMO = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [6:0]  LUI = 7'b0110111;
  localparam logic [6:0]  AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [6:0]  ex_op;
  logic [19:0] ex_imm;
  logic [31:0] ex_pc;
  logic [31:0] ex_result;
  logic [1:0]  ex_pcop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        halt_req;
  logic        halted;
  logic        fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] res_offset;
  logic [1:0]  pcop_drv;

  u_pc_sequencer #(
    .RESET_PC (RST_PC),
    .FETCH_TMO(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .ex_op     (ex_op),
    .ex_imm    (ex_imm),
    .ex_pc     (ex_pc),
    .ex_result (ex_result),
    .ex_pcop   (ex_pcop),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pc        (pc),
    .halt_req  (halt_req),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // External exec unit model; res_offset lets the bench exercise jump alignment.
  always_comb begin
    case (ex_op)
      LUI:     ex_result = {ex_imm, 12'b0} + res_offset;
      AUIPC:   ex_result = {ex_imm, 12'b0} + ex_pc + res_offset;
      default: ex_result = 32'd0;
    endcase
  end
  assign ex_pcop = pcop_drv;

  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    halt_req   = 1'b0;
    res_offset = 32'd0;
    pcop_drv   = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    m_pc = RST_PC;
  endtask

  // Runs one instruction from FETCH and checks it against the model result.
  task automatic exec_instr(input logic [31:0] instr, input logic [1:0] pcop,
                            input int stall, input logic halt_at_exec);
    logic [31:0] u;
    logic [31:0] exp_res;
    logic [4:0]  rd;
    logic        legal;
    u     = {instr[31:12], 12'b0};
    rd    = instr[11:7];
    legal = (instr[6:0] == LUI) || (instr[6:0] == AUIPC);
    exp_res = ((instr[6:0] == AUIPC) ? u + m_pc : u) + res_offset;
    pcop_drv = pcop;
    for (int i = 0; i <= stall; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        errors++;
        $display("[TB] FAIL fetch_req cyc%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, m_pc);
      end
      imem_ready = (i == stall);
      imem_rdata = instr;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    if (!legal) begin
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("[TB] FAIL illegal_op got fault=%b req=%b we=%b pc=%h exp fault=1 req=0 we=0 pc=%h", fault, imem_req, rf_we, pc, m_pc);
      end
      return;
    end
    @(negedge clk);
    if (halt_at_exec) halt_req = 1'b1;
    checks++;
    if (ex_op !== instr[6:0] || ex_imm !== instr[31:12] || ex_pc !== m_pc) begin
      errors++;
      $display("[TB] FAIL exec_drive got op=%h imm=%h pc=%h exp op=%h imm=%h pc=%h", ex_op, ex_imm, ex_pc, instr[6:0], instr[31:12], m_pc);
    end
    @(negedge clk);
    checks++;
    if (pcop == 2'd3 || rd == 5'd0) begin
      if (rf_we !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wb_nowrite got we=%b exp we=0", rf_we);
      end
    end else if (rf_we !== 1'b1 || rf_waddr !== rd || rf_wdata !== exp_res) begin
      errors++;
      $display("[TB] FAIL wb_write got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h", rf_we, rf_waddr, rf_wdata, rd, exp_res);
    end
    @(negedge clk);
    if (pcop == 2'd2) m_pc = exp_res & ~32'h3;
    else if (pcop != 2'd3) m_pc = m_pc + 32'd4;
    checks++;
    if (pc !== m_pc || fault !== (pcop == 2'd3)) begin
      errors++;
      $display("[TB] FAIL pc_update got pc=%h fault=%b exp pc=%h fault=%b", pc, fault, m_pc, (pcop == 2'd3));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== RST_PC || imem_req !== 1'b1 || imem_addr !== RST_PC || rf_we !== 1'b0 ||
        ex_op !== 7'd0 || halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got pc=%h req=%b addr=%h we=%b op=%h halted=%b fault=%b", pc, imem_req, imem_addr, rf_we, ex_op, halted, fault);
    end
  endtask

  task automatic test_lui();
    exec_instr(32'h1234_50B7, 2'd0, 0, 1'b0);
    checks++;
    if (pc !== 32'h4) begin
      errors++;
      $display("[TB] FAIL lui_pc got %h exp 00000004", pc);
    end
  endtask

  task automatic test_auipc();
    res_offset = 32'h100;
    exec_instr({20'h0, 5'd0, LUI}, 2'd2, 0, 1'b0);
    res_offset = 32'h0;
    exec_instr(32'h0000_1117, 2'd0, 0, 1'b0);
    checks++;
    if (pc !== 32'h104) begin
      errors++;
      $display("[TB] FAIL auipc_pc got %h exp 00000104", pc);
    end
  endtask

  task automatic test_wrap();
    res_offset = 32'hFFE;
    exec_instr({20'hFFFFF, 5'd3, LUI}, 2'd2, 1, 1'b0);
    res_offset = 32'h0;
    exec_instr({20'hABCDE, 5'd0, LUI}, 2'd1, 0, 1'b0);
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_pc got %h exp 00000000", pc);
    end
  endtask

  task automatic test_stall();
    exec_instr({20'h00042, 5'd7, AUIPC}, 2'd0, 5, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic [1:0]  pcop;
    for (int n = 0; n < 40; n++) begin
      instr[31:7] = 25'($urandom);
      instr[6:0]  = ($urandom_range(0, 1) == 0) ? LUI : AUIPC;
      pcop        = 2'($urandom_range(0, 2));
      res_offset  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4095)) : 32'd0;
      exec_instr(instr, pcop, $urandom_range(0, 6), 1'b0);
    end
    res_offset = 32'd0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < int'(TMO); i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC || fault !== 1'b0) begin
        errors++;
        $display("[TB] FAIL tmo_wait cyc%0d got req=%b addr=%h fault=%b exp req=1 addr=%h fault=0", i, imem_req, imem_addr, fault, RST_PC);
      end
      @(negedge clk);
    end
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== RST_PC) begin
      errors++;
      $display("[TB] FAIL tmo_fault got fault=%b req=%b pc=%h exp fault=1 req=0 pc=%h", fault, imem_req, pc, RST_PC);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    exec_instr(32'h0000_40B7, 2'd0, 0, 1'b0);
    exec_instr({20'h11111, 5'd4, 7'b0110011}, 2'd0, 2, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h4) begin
      errors++;
      $display("[TB] FAIL illegal_sticky got fault=%b req=%b pc=%h exp fault=1 req=0 pc=00000004", fault, imem_req, pc);
    end
  endtask

  task automatic test_pcop_fault();
    do_reset();
    exec_instr({20'h0ABCD, 5'd5, LUI}, 2'd0, 0, 1'b0);
    exec_instr({20'h0ABCD, 5'd5, AUIPC}, 2'd3, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || pc !== 32'h4 || rf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pcop3_sticky got fault=%b pc=%h we=%b exp fault=1 pc=00000004 we=0", fault, pc, rf_we);
    end
  endtask

  task automatic test_halt();
    do_reset();
    exec_instr({20'h00077, 5'd9, LUI}, 2'd0, 0, 1'b1);
    checks++;
    if (imem_req !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_entry got req=%b halted=%b exp req=0 halted=0", imem_req, halted);
    end
    @(negedge clk);
    halt_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h4 || fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_hold got halted=%b req=%b pc=%h fault=%b exp halted=1 req=0 pc=00000004 fault=0", halted, imem_req, pc, fault);
    end
  endtask

  task automatic test_rst_mid_wb();
    do_reset();
    exec_instr({20'h00010, 5'd1, LUI}, 2'd0, 0, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = {20'h00020, 5'd2, LUI};
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd2) begin
      errors++;
      $display("[TB] FAIL rst_pre_wb got we=%b rd=%0d exp we=1 rd=2", rf_we, rf_waddr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pc !== RST_PC || rf_we !== 1'b0 || fault !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_wb got pc=%h we=%b fault=%b halted=%b exp pc=%h we=0", pc, rf_we, fault, halted, RST_PC);
    end
    rst  = 1'b0;
    m_pc = RST_PC;
    exec_instr({20'h00030, 5'd3, AUIPC}, 2'd0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lui();
    test_auipc();
    test_wrap();
    test_stall();
    test_random();
    test_timeout();
    test_illegal();
    test_pcop_fault();
    test_halt();
    test_rst_mid_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
